interrupt_controller: RTL and testbench

Sequences the fifteen device interrupt request lines, codes 1-15, towards the CPU. It edge-detects and latches each request and applies a software-writable enable mask. It then selects the highest-priority pending code and presents it with a request/acknowledge/end-of-interrupt handshake. It sits between the interrupt request splitter and the CPU core's interrupt input, and allows one interrupt in service at a time (no nesting).

---
 rtl/interrupt_controller_if.sv | 25 ++
 rtl/interrupt_controller.sv | 117 +++++++++++
 tb/tb_interrupt_controller.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/interrupt_controller_if.sv
// Request, mask and CPU handshake bundle for the interrupt controller.
interface interrupt_controller_if;
    logic [15:1] requests;
    logic        mask_we;
    logic [15:1] mask_wdata;
    logic        intr_ack;
    logic        intr_eoi;
    logic        intr;
    logic [3:0]  intr_code;
    logic        in_service;
    logic [15:1] pending;
    logic [15:1] enable;

    // Requester/CPU side: drives requests, mask writes and the handshake.
    modport master (
        output requests, mask_we, mask_wdata, intr_ack, intr_eoi,
        input  intr, intr_code, in_service, pending, enable
    );

    // Controller side.
    modport slave (
        input  requests, mask_we, mask_wdata, intr_ack, intr_eoi,
        output intr, intr_code, in_service, pending, enable
    );
endinterface

// File: rtl/interrupt_controller.sv
// Fifteen-line interrupt controller: edge latch, enable mask, fixed priority
// (code 1 highest), one interrupt in service at a time.
module interrupt_controller (
    input  logic                   clk,
    input  logic                   rst,
    interrupt_controller_if.slave  bus
);
    localparam int unsigned NUM_LINES = 15;
    localparam int unsigned CODE_W    = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t                state;
    logic [NUM_LINES:1]    req_prev;
    logic [NUM_LINES:1]    pending_q;
    logic [NUM_LINES:1]    enable_q;
    logic                  intr_q;
    logic [CODE_W-1:0]     intr_code_q;
    logic                  in_service_q;

    logic [NUM_LINES:1]    req_edge;
    logic [NUM_LINES:1]    eligible;
    logic [NUM_LINES:1]    ack_clr;
    logic [CODE_W-1:0]     winner;
    logic                  ack_accept;

    assign req_edge   = bus.requests & ~req_prev;
    assign eligible   = pending_q & enable_q;
    assign ack_accept = (state == REQUEST) && bus.intr_ack;

    // Lowest eligible index wins; scanning downward lets the last hit stand.
    always_comb begin
        winner = '0;
        for (int i = NUM_LINES; i >= 1; i--) begin
            if (eligible[i]) begin
                winner = CODE_W'(i);
            end
        end
    end

    // One-hot clear of the presented line on an accepted acknowledge.
    always_comb begin
        ack_clr = '0;
        if (ack_accept) begin
            for (int i = 1; i <= NUM_LINES; i++) begin
                ack_clr[i] = (intr_code_q == CODE_W'(i));
            end
        end
    end

    // Edge history, pending latch (set wins over clear) and enable mask.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_prev  <= '0;
            pending_q <= '0;
            enable_q  <= '0;
        end else begin
            req_prev  <= bus.requests;
            pending_q <= (pending_q & ~ack_clr) | req_edge;
            if (bus.mask_we) begin
                enable_q <= bus.mask_wdata;
            end
        end
    end

    // Handshake FSM with registered outputs; the code is frozen outside IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            intr_q       <= 1'b0;
            intr_code_q  <= '0;
            in_service_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (eligible != '0) begin
                        state       <= REQUEST;
                        intr_q      <= 1'b1;
                        intr_code_q <= winner;
                    end else begin
                        intr_code_q <= '0;
                    end
                end
                REQUEST: begin
                    if (bus.intr_ack) begin
                        state        <= SERVICE;
                        intr_q       <= 1'b0;
                        in_service_q <= 1'b1;
                    end
                end
                SERVICE: begin
                    if (bus.intr_eoi) begin
                        state        <= IDLE;
                        in_service_q <= 1'b0;
                        intr_code_q  <= '0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    intr_q       <= 1'b0;
                    intr_code_q  <= '0;
                    in_service_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.intr       = intr_q;
    assign bus.intr_code  = intr_code_q;
    assign bus.in_service = in_service_q;
    assign bus.pending    = pending_q;
    assign bus.enable     = enable_q;
endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller.
module tb_interrupt_controller;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    interrupt_controller_if bus ();

    interrupt_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n clocks; inputs are driven and outputs sampled 1ns after the edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ack_pulse();
        bus.intr_ack = 1'b1;
        cyc(1);
        bus.intr_ack = 1'b0;
    endtask

    task automatic eoi_pulse();
        bus.intr_eoi = 1'b1;
        cyc(1);
        bus.intr_eoi = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (bus.intr !== 1'b0) begin errors++; $display("FAIL reset_intr got %b exp 0", bus.intr); end
        checks++; if (bus.intr_code !== 4'd0) begin errors++; $display("FAIL reset_code got %0d exp 0", bus.intr_code); end
        checks++; if (bus.in_service !== 1'b0) begin errors++; $display("FAIL reset_insvc got %b exp 0", bus.in_service); end
        checks++; if (bus.pending !== 15'h0000) begin errors++; $display("FAIL reset_pending got %h exp 0000", bus.pending); end
        checks++; if (bus.enable !== 15'h0000) begin errors++; $display("FAIL reset_enable got %h exp 0000", bus.enable); end
        cyc(2);
        rst = 1'b0;
        cyc(1);
    endtask

    task automatic test_mask();
        bus.requests[2] = 1'b1;
        cyc(1);
        bus.requests[2] = 1'b0;
        checks++; if (bus.pending !== 15'h0002) begin errors++; $display("FAIL mask_pending got %h exp 0002", bus.pending); end
        cyc(2);
        checks++; if (bus.intr !== 1'b0) begin errors++; $display("FAIL mask_intr_masked got %b exp 0", bus.intr); end
        bus.mask_we    = 1'b1;
        bus.mask_wdata = 15'h7FFF;
        cyc(1);
        bus.mask_we = 1'b0;
        checks++; if (bus.enable !== 15'h7FFF) begin errors++; $display("FAIL mask_enable got %h exp 7fff", bus.enable); end
        checks++; if (bus.intr !== 1'b0) begin errors++; $display("FAIL mask_intr_early got %b exp 0", bus.intr); end
        cyc(1);
        checks++; if (bus.intr !== 1'b1 || bus.intr_code !== 4'd2) begin errors++; $display("FAIL mask_present got intr=%b code=%0d exp intr=1 code=2", bus.intr, bus.intr_code); end
        ack_pulse();
        checks++; if (bus.pending !== 15'h0000) begin errors++; $display("FAIL mask_pending_clr got %h exp 0000", bus.pending); end
        eoi_pulse();
        cyc(1);
    endtask

    task automatic test_priority();
        bus.requests[5] = 1'b1;
        bus.requests[3] = 1'b1;
        cyc(1);
        bus.requests = '0;
        checks++; if (bus.pending !== 15'h0014) begin errors++; $display("FAIL prio_pending got %h exp 0014", bus.pending); end
        cyc(1);
        checks++; if (bus.intr !== 1'b1 || bus.intr_code !== 4'd3) begin errors++; $display("FAIL prio_first got intr=%b code=%0d exp intr=1 code=3", bus.intr, bus.intr_code); end
        ack_pulse();
        checks++; if (bus.pending !== 15'h0010) begin errors++; $display("FAIL prio_pending_mid got %h exp 0010", bus.pending); end
        eoi_pulse();
        checks++; if (bus.intr !== 1'b0 || bus.intr_code !== 4'd0) begin errors++; $display("FAIL prio_gap got intr=%b code=%0d exp intr=0 code=0", bus.intr, bus.intr_code); end
        cyc(1);
        checks++; if (bus.intr !== 1'b1 || bus.intr_code !== 4'd5) begin errors++; $display("FAIL prio_second got intr=%b code=%0d exp intr=1 code=5", bus.intr, bus.intr_code); end
        ack_pulse();
        checks++; if (bus.pending !== 15'h0000) begin errors++; $display("FAIL prio_pending_end got %h exp 0000", bus.pending); end
        eoi_pulse();
        cyc(1);
    endtask

    task automatic test_handshake();
        bus.requests[6] = 1'b1;
        cyc(1);
        bus.requests[6] = 1'b0;
        cyc(1);
        for (int k = 0; k < 10; k++) begin
            checks++; if (bus.intr !== 1'b1 || bus.intr_code !== 4'd6) begin errors++; $display("FAIL hs_hold cycle %0d got intr=%b code=%0d exp intr=1 code=6", k, bus.intr, bus.intr_code); end
            cyc(1);
        end
        eoi_pulse();
        checks++; if (bus.intr !== 1'b1 || bus.in_service !== 1'b0) begin errors++; $display("FAIL hs_early_eoi got intr=%b insvc=%b exp intr=1 insvc=0", bus.intr, bus.in_service); end
        ack_pulse();
        checks++; if (bus.intr !== 1'b0 || bus.in_service !== 1'b1 || bus.intr_code !== 4'd6) begin errors++; $display("FAIL hs_ack got intr=%b insvc=%b code=%0d exp intr=0 insvc=1 code=6", bus.intr, bus.in_service, bus.intr_code); end
        ack_pulse();
        checks++; if (bus.in_service !== 1'b1 || bus.intr !== 1'b0) begin errors++; $display("FAIL hs_stray_ack got intr=%b insvc=%b exp intr=0 insvc=1", bus.intr, bus.in_service); end
        eoi_pulse();
        checks++; if (bus.intr_code !== 4'd0 || bus.in_service !== 1'b0) begin errors++; $display("FAIL hs_eoi got code=%0d insvc=%b exp code=0 insvc=0", bus.intr_code, bus.in_service); end
        cyc(1);
    endtask

    task automatic test_nonpreempt();
        bus.requests[4] = 1'b1;
        cyc(1);
        bus.requests[4] = 1'b0;
        cyc(1);
        ack_pulse();
        bus.requests[4] = 1'b1;
        bus.requests[1] = 1'b1;
        cyc(1);
        bus.requests = '0;
        cyc(1);
        bus.requests[4] = 1'b1;
        cyc(1);
        bus.requests[4] = 1'b0;
        cyc(1);
        checks++; if (bus.pending !== 15'h0009) begin errors++; $display("FAIL np_pending got %h exp 0009", bus.pending); end
        checks++; if (bus.in_service !== 1'b1 || bus.intr_code !== 4'd4 || bus.intr !== 1'b0) begin errors++; $display("FAIL np_no_preempt got intr=%b insvc=%b code=%0d exp intr=0 insvc=1 code=4", bus.intr, bus.in_service, bus.intr_code); end
        eoi_pulse();
        cyc(1);
        checks++; if (bus.intr !== 1'b1 || bus.intr_code !== 4'd1) begin errors++; $display("FAIL np_first got intr=%b code=%0d exp intr=1 code=1", bus.intr, bus.intr_code); end
        ack_pulse();
        eoi_pulse();
        cyc(1);
        checks++; if (bus.intr !== 1'b1 || bus.intr_code !== 4'd4) begin errors++; $display("FAIL np_second got intr=%b code=%0d exp intr=1 code=4", bus.intr, bus.intr_code); end
        ack_pulse();
        checks++; if (bus.pending !== 15'h0000) begin errors++; $display("FAIL np_coalesce got %h exp 0000", bus.pending); end
        eoi_pulse();
        cyc(3);
        checks++; if (bus.intr !== 1'b0) begin errors++; $display("FAIL np_once got intr=%b exp 0", bus.intr); end
    endtask

    task automatic test_set_wins();
        bus.requests[3] = 1'b1;
        cyc(1);
        bus.requests[3] = 1'b0;
        cyc(1);
        checks++; if (bus.intr !== 1'b1 || bus.intr_code !== 4'd3) begin errors++; $display("FAIL sw_present got intr=%b code=%0d exp intr=1 code=3", bus.intr, bus.intr_code); end
        bus.requests[3] = 1'b1;
        ack_pulse();
        bus.requests[3] = 1'b0;
        checks++; if (bus.pending !== 15'h0004 || bus.in_service !== 1'b1) begin errors++; $display("FAIL sw_pending got pending=%h insvc=%b exp pending=0004 insvc=1", bus.pending, bus.in_service); end
        eoi_pulse();
        cyc(1);
        checks++; if (bus.intr !== 1'b1 || bus.intr_code !== 4'd3) begin errors++; $display("FAIL sw_again got intr=%b code=%0d exp intr=1 code=3", bus.intr, bus.intr_code); end
        ack_pulse();
        checks++; if (bus.pending !== 15'h0000) begin errors++; $display("FAIL sw_pending_clr got %h exp 0000", bus.pending); end
        eoi_pulse();
        cyc(1);
    endtask

    task automatic test_reset_mid();
        bus.requests[2] = 1'b1;
        cyc(1);
        bus.requests[2] = 1'b0;
        cyc(1);
        ack_pulse();
        checks++; if (bus.in_service !== 1'b1) begin errors++; $display("FAIL rm_in_service got %b exp 1", bus.in_service); end
        cyc(1);
        #2;
        rst = 1'b1;
        bus.requests[7] = 1'b1;
        #1;
        checks++; if (bus.intr !== 1'b0 || bus.intr_code !== 4'd0 || bus.in_service !== 1'b0) begin errors++; $display("FAIL rm_async got intr=%b code=%0d insvc=%b exp all 0", bus.intr, bus.intr_code, bus.in_service); end
        checks++; if (bus.pending !== 15'h0000 || bus.enable !== 15'h0000) begin errors++; $display("FAIL rm_async_regs got pending=%h enable=%h exp 0000/0000", bus.pending, bus.enable); end
        cyc(2);
        rst            = 1'b0;
        bus.mask_we    = 1'b1;
        bus.mask_wdata = 15'h0040;
        cyc(1);
        bus.mask_we = 1'b0;
        checks++; if (bus.pending !== 15'h0040 || bus.enable !== 15'h0040) begin errors++; $display("FAIL rm_first_edge got pending=%h enable=%h exp 0040/0040", bus.pending, bus.enable); end
        cyc(1);
        checks++; if (bus.intr !== 1'b1 || bus.intr_code !== 4'd7) begin errors++; $display("FAIL rm_present got intr=%b code=%0d exp intr=1 code=7", bus.intr, bus.intr_code); end
        ack_pulse();
        eoi_pulse();
        cyc(3);
        checks++; if (bus.intr !== 1'b0 || bus.pending !== 15'h0000) begin errors++; $display("FAIL rm_once got intr=%b pending=%h exp intr=0 pending=0000", bus.intr, bus.pending); end
        bus.requests = '0;
        cyc(1);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        bus.requests   = '0;
        bus.mask_we    = 1'b0;
        bus.mask_wdata = '0;
        bus.intr_ack   = 1'b0;
        bus.intr_eoi   = 1'b0;
        test_reset();
        test_mask();
        test_priority();
        test_handshake();
        test_nonpreempt();
        test_set_wins();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
